// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
//   Passive I2C bus observer. SCL/SDA are synchronized into i_clk, START,
//   repeated START, STOP and complete bytes are decoded, and each event is
//   queued in a small FIFO that the consumer drains with a valid/ready pair.
//
// Parameters
//   FIFO_DEPTH  : event FIFO entries (power of 2, >= 2)
//   SYNC_STAGES : synchronizer flops per bus line (>= 2)
//
// Ports
//   i_clk        : sole clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_scl/i_sda  : raw bus lines, asynchronous to i_clk
//   i_ready      : consumer takes the FIFO head this cycle
//   o_valid      : FIFO head valid
//   o_tag        : head type (00 byte, 01 start, 10 repeat start, 11 stop)
//   o_byte       : head payload {data[7:0], ack}, 0 for non-byte tags
//   o_busy       : bus is between START and STOP
//   o_frame_err  : one-cycle pulse, START/STOP seen inside a partial byte
//   o_overflow   : sticky, an event was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module i2c_bus_monitor #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [1:0] o_tag,
    output logic [8:0] o_byte,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] TAG_BYTE   = 2'b00;
    localparam logic [1:0] TAG_START  = 2'b01;
    localparam logic [1:0] TAG_RSTART = 2'b10;
    localparam logic [1:0] TAG_STOP   = 2'b11;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    // -----------------------------------------------------------------------
    // Synchronizers plus one "previous" register per line. Everything resets
    // to 1 so that releasing reset onto an idle (high) bus looks like no
    // change at all.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_cur, sda_cur;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_cur = scl_sync[SYNC_STAGES-1];
    assign sda_cur = sda_sync[SYNC_STAGES-1];

    // START/STOP need SCL stable high across the sample pair, so an SDA
    // change landing together with an SCL change is never a condition; that
    // sample is treated as a plain SCL edge with the new SDA value.
    logic start_det, stop_det, scl_rise;

    assign start_det = scl_cur & scl_prev &  sda_prev & ~sda_cur;
    assign stop_det  = scl_cur & scl_prev & ~sda_prev &  sda_cur;
    assign scl_rise  = scl_cur & ~scl_prev;

    // -----------------------------------------------------------------------
    // Protocol FSM
    // -----------------------------------------------------------------------
    state_t     state, state_nxt;
    logic [3:0] bit_cnt;
    logic [7:0] shift;

    logic       evt_push;
    logic [1:0] evt_tag;
    logic [8:0] evt_byte;
    logic       frame_err_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = ACTIVE;
            ACTIVE:  if (stop_det)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Event generation. At most one event per cycle: START/STOP require SCL
    // steady, the 9th bit requires an SCL rising edge.
    always_comb begin
        evt_push    = 1'b0;
        evt_tag     = TAG_BYTE;
        evt_byte    = '0;
        frame_err_d = 1'b0;
        if (start_det) begin
            evt_push    = 1'b1;
            evt_tag     = (state == ACTIVE) ? TAG_RSTART : TAG_START;
            frame_err_d = (bit_cnt != 4'd0);
        end else if (stop_det) begin
            evt_push    = 1'b1;
            evt_tag     = TAG_STOP;
            frame_err_d = (bit_cnt != 4'd0);
        end else if (state == ACTIVE && scl_rise && bit_cnt == 4'd8) begin
            evt_push = 1'b1;
            evt_tag  = TAG_BYTE;
            evt_byte = {shift, sda_cur};
        end
    end

    // Bit collector: counts samples 0..8; the 9th sample (ack) is taken
    // directly from the line when the byte is pushed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt <= 4'd0;
            shift   <= 8'd0;
        end else if (start_det || stop_det) begin
            bit_cnt <= 4'd0;
            shift   <= 8'd0;
        end else if (state == ACTIVE && scl_rise) begin
            if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                shift   <= 8'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shift   <= {shift[6:0], sda_cur};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_busy      <= (state_nxt == ACTIVE);
            o_frame_err <= frame_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Event FIFO. Pointers carry one extra wrap bit. The head is presented
    // through registered outputs: a pop takes effect at once, while a fresh
    // push becomes visible one cycle after it is written.
    // -----------------------------------------------------------------------
    logic [10:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic        pop, full, do_push, head_avail;

    assign pop        = o_valid & i_ready;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // When full, a same-cycle pop frees the slot being written.
    assign do_push    = evt_push & (~full | pop);
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    // Head for next cycle only considers entries written before this edge.
    assign head_avail = (wr_ptr != rd_ptr_nxt);

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {evt_tag, evt_byte};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_valid    <= 1'b0;
            o_tag      <= 2'b00;
            o_byte     <= 9'd0;
            o_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            rd_ptr  <= rd_ptr_nxt;
            o_valid <= head_avail;
            if (head_avail) {o_tag, o_byte} <= mem[rd_ptr_nxt[AW-1:0]];
            if (evt_push && full && !pop) o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
module tb_i2c_bus_monitor;

    logic       i_clk = 1'b0;
    logic       i_rst, i_scl, i_sda, i_ready;
    logic       o_valid, o_busy, o_frame_err, o_overflow;
    logic [1:0] o_tag;
    logic [8:0] o_byte;

    i2c_bus_monitor #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_scl(i_scl), .i_sda(i_sda),
        .i_ready(i_ready), .o_valid(o_valid), .o_tag(o_tag), .o_byte(o_byte),
        .o_busy(o_busy), .o_frame_err(o_frame_err), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [1:0] tag; logic [8:0] byt; } ev_t;
    typedef struct { logic scl; logic sda; logic exp_busy; } step_t;

    ev_t   got_q[$];
    ev_t   exp_q[$];
    step_t steps[$];
    logic  last_sda;
    int    fe_cnt = 0;
    int    n_cmp = 0, n_err = 0;
    int    base, fe0;

    // Records every head taken by the consumer and counts frame-error pulses.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) got_q.push_back('{o_tag, o_byte});
            if (o_frame_err) fe_cnt++;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic bus(input logic c, input logic d);
        i_scl = c; i_sda = d; hold(6);
    endtask

    task automatic add(input logic c, input logic d, input logic b);
        steps.push_back('{c, d, b});
        last_sda = d;
    endtask

    task automatic add_bit(input logic b);
        add(1'b0, last_sda, 1'b1);
        add(1'b0, b, 1'b1);
        add(1'b1, b, 1'b1);
    endtask

    task automatic add_byte(input logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) add_bit(v[i]);
        add_bit(ack);
    endtask

    task automatic run_steps(input string name);
        foreach (steps[i]) begin
            bus(steps[i].scl, steps[i].sda);
            check($sformatf("%s busy step %0d", name, i), {15'd0, o_busy}, {15'd0, steps[i].exp_busy});
        end
        steps.delete();
    endtask

    task automatic ev(input logic [1:0] t, input logic [8:0] b);
        exp_q.push_back('{t, b});
    endtask

    task automatic expect_events(input string name, input int b0);
        check($sformatf("%s event count", name), 16'(got_q.size() - b0), 16'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (b0 + i < got_q.size()) begin
                check($sformatf("%s ev%0d tag", name, i), {14'd0, got_q[b0+i].tag}, {14'd0, exp_q[i].tag});
                check($sformatf("%s ev%0d byte", name, i), {7'd0, got_q[b0+i].byt}, {7'd0, exp_q[i].byt});
            end
        end
        exp_q.delete();
    endtask

    task automatic drain(input int target);
        int budget;
        budget = 200;
        i_ready = 1'b1;
        while (got_q.size() < target && budget > 0) begin hold(1); budget--; end
        i_ready = 1'b0;
        hold(6);
        if (budget == 0) check("drain timeout", 16'(got_q.size()), 16'(target));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " o_valid"},     {15'd0, o_valid},     16'd0);
        check({name, " o_tag"},       {14'd0, o_tag},       16'd0);
        check({name, " o_byte"},      {7'd0, o_byte},       16'd0);
        check({name, " o_busy"},      {15'd0, o_busy},      16'd0);
        check({name, " o_frame_err"}, {15'd0, o_frame_err}, 16'd0);
        check({name, " o_overflow"},  {15'd0, o_overflow},  16'd0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_scl = 1'b1; i_sda = 1'b1; i_ready = 1'b0; last_sda = 1'b1;
        hold(3);
        i_rst = 1'b0;
        hold(3);
    endtask

    initial begin
        i_rst = 1'b1; i_scl = 1'b1; i_sda = 1'b1; i_ready = 1'b0; last_sda = 1'b1;
        hold(3);
        check_reset_outputs("reset");
        i_rst = 1'b0;
        hold(10);
        check("idle release o_valid", {15'd0, o_valid}, 16'd0);
        check("idle release o_busy",  {15'd0, o_busy},  16'd0);

        // Start latency: o_valid must appear on the 4th edge after SDA falls.
        i_sda = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            hold(1);
            check($sformatf("latency edge %0d o_valid", e), {15'd0, o_valid}, (e == 4) ? 16'd1 : 16'd0);
        end
        check("latency head tag", {14'd0, o_tag}, 16'h1);
        do_reset();

        // Address 0xA4, ack 0, stop taken while SCL is high after the ack.
        i_ready = 1'b1; base = got_q.size(); fe0 = fe_cnt;
        add(1, 0, 1); add_byte(8'hA4, 1'b0); add(1, 1, 0);
        run_steps("a4");
        hold(4);
        ev(2'b01, 9'h0); ev(2'b00, 9'h148); ev(2'b11, 9'h0);
        expect_events("a4", base);
        check("a4 frame_err", 16'(fe_cnt - fe0), 16'd0);
        check("a4 overflow", {15'd0, o_overflow}, 16'd0);

        // 0x90 ack 0, repeated start, 0x91 ack 1, stop.
        base = got_q.size();
        add(1, 0, 1); add_byte(8'h90, 1'b0);
        add(0, 0, 1); add(0, 1, 1); add(1, 1, 1); add(1, 0, 1);
        add_byte(8'h91, 1'b1);
        add(0, 1, 1); add(0, 0, 1); add(1, 0, 1); add(1, 1, 0);
        run_steps("rs");
        hold(4);
        ev(2'b01, 9'h0); ev(2'b00, 9'h120); ev(2'b10, 9'h0); ev(2'b00, 9'h123); ev(2'b11, 9'h0);
        expect_events("rs", base);

        // Stop after 4 data bits: frame error, no byte.
        base = got_q.size(); fe0 = fe_cnt;
        add(1, 0, 1); add_bit(1); add_bit(0); add_bit(1); add_bit(0); add(1, 1, 0);
        run_steps("part");
        hold(4);
        ev(2'b01, 9'h0); ev(2'b11, 9'h0);
        expect_events("part", base);
        check("part frame_err pulses", 16'(fe_cnt - fe0), 16'd1);

        // Overflow: 7 events into a 4-deep FIFO with the consumer stalled.
        do_reset();
        base = got_q.size();
        add(1, 0, 1);
        add_byte(8'h11, 0); add_byte(8'h22, 0); add_byte(8'h33, 0);
        add_byte(8'h44, 0); add_byte(8'h55, 0);
        add(1, 1, 0);
        run_steps("ovf");
        check("ovf o_overflow", {15'd0, o_overflow}, 16'd1);
        check("ovf o_valid", {15'd0, o_valid}, 16'd1);
        check("ovf head tag", {14'd0, o_tag}, 16'h1);
        drain(base + 4);
        ev(2'b01, 9'h0); ev(2'b00, 9'h022); ev(2'b00, 9'h044); ev(2'b00, 9'h066);
        expect_events("ovf", base);
        check("ovf empty after drain", {15'd0, o_valid}, 16'd0);
        check("ovf sticky", {15'd0, o_overflow}, 16'd1);

        // Full FIFO, push and pop on the same edge.
        do_reset();
        base = got_q.size();
        add(1, 0, 1); add_byte(8'h11, 0); add_byte(8'h22, 0); add_byte(8'h33, 0);
        run_steps("fpp");
        check("fpp o_valid", {15'd0, o_valid}, 16'd1);
        i_sda = 1'b1;          // stop, pushed on the 3rd edge from here
        hold(2);
        i_ready = 1'b1;
        hold(1);
        i_ready = 1'b0;
        hold(6);
        check("fpp one pop", 16'(got_q.size() - base), 16'd1);
        check("fpp o_overflow", {15'd0, o_overflow}, 16'd0);
        check("fpp o_busy", {15'd0, o_busy}, 16'd0);
        drain(base + 5);
        ev(2'b01, 9'h0); ev(2'b00, 9'h022); ev(2'b00, 9'h044); ev(2'b00, 9'h066); ev(2'b11, 9'h0);
        expect_events("fpp", base);

        // Reset in the middle of a byte, then SCL activity with no start.
        do_reset();
        add(1, 0, 1); add_bit(1); add_bit(0); add_bit(1);
        run_steps("mid");
        check("mid o_valid before reset", {15'd0, o_valid}, 16'd1);
        i_rst = 1'b1;
        #1;
        check_reset_outputs("mid async");
        hold(2);
        i_rst = 1'b0;
        hold(4);
        base = got_q.size(); fe0 = fe_cnt;
        i_ready = 1'b1;
        add(0, 1, 0); add(0, 0, 0); add(1, 0, 0); add(0, 0, 0);
        add(0, 1, 0); add(1, 1, 0); add(0, 1, 0); add(1, 1, 0);
        run_steps("post");
        hold(4);
        i_ready = 1'b0;
        check("post no events", 16'(got_q.size() - base), 16'd0);
        check("post o_valid", {15'd0, o_valid}, 16'd0);
        check("post frame_err", 16'(fe_cnt - fe0), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_bus_monitor.md
I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per bus line (>=2).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_scl  input  1  bus SCL, asynchronous to i_clk.
REQ-006 SHALL have port i_sda  input  1  bus SDA, asynchronous to i_clk.
REQ-007 SHALL have port i_ready  input  1  consumer accepts FIFO head this cycle.
REQ-008 SHALL have port o_valid  output  1  FIFO head valid.
REQ-009 SHALL have port o_tag  output  2  head type: 00 byte, 01 start, 10 repeat start, 11 stop.
REQ-010 SHALL have port o_byte  output  9  head payload {data[7:0] MSB-first, ack bit}; 0 for non-byte tags.
REQ-011 SHALL have port o_busy  output  1  high between start and stop.
REQ-012 SHALL have port o_frame_err  output  1  one-cycle pulse: start/stop inside a partial byte.
REQ-013 SHALL have port o_overflow  output  1  sticky: an event was dropped on full FIFO.

Function
REQ-014 SHALL pass i_scl/i_sda through SYNC_STAGES flops (reset value 1), then one "previous" register each; all detection uses synchronized current vs previous.
REQ-015 SHALL detect start: SDA 1->0 while SCL current and previous both 1.
REQ-016 SHALL detect stop: SDA 0->1 while SCL current and previous both 1.
REQ-017 SHALL, when SCL and SDA change in the same sample, detect no start/stop; SCL edge processed with the new SDA value.
REQ-018 SHALL implement FSM IDLE/ACTIVE: IDLE--start-->ACTIVE (push tag 01); ACTIVE--start-->ACTIVE (push tag 10); ACTIVE--stop-->IDLE (push tag 11); IDLE--stop-->IDLE (push tag 11, o_busy stays 0).
REQ-019 SHALL in IDLE ignore SCL edges (no bit collection).
REQ-020 SHALL in ACTIVE sample SDA on each synchronized SCL rising edge into a shift register; bit counter 0..8; on the 9th sample push tag 00 with {8 data, ack} and clear counter.
REQ-021 SHALL clear bit counter and shift register on every start/stop.
REQ-022 SHALL pulse o_frame_err one cycle when start or stop is detected with bit counter in 1..8; partial byte discarded, start/stop event still pushed.
REQ-023 SHALL drive o_busy = (state == ACTIVE), registered.
REQ-024 SHALL push each event in the cycle it is detected; o_valid rises the next cycle when FIFO was empty: total SYNC_STAGES+2 i_clk edges from bus-line change to o_valid.
REQ-025 SHALL pop the head on the rising edge where o_valid && i_ready; o_tag/o_byte change only on pop or empty->non-empty.
REQ-026 SHALL ignore i_ready while o_valid is 0.
REQ-027 SHALL, on push while full and no pop in the same cycle, drop the event and set o_overflow until reset.
REQ-028 SHALL, on push and pop in the same cycle while full, accept both; no overflow.
REQ-029 SHALL use log2(FIFO_DEPTH)+1-bit read/write pointers wrapping modulo 2*FIFO_DEPTH; full = MSBs differ and remaining bits equal; empty = pointers equal.
REQ-030 SHALL never push more than one event per cycle (start/stop and 9th-bit edge are mutually exclusive by REQ-017).

Reset
REQ-031 SHALL, on i_rst high, immediately force: state IDLE, counter 0, pointers 0, sync/previous regs 1, o_valid 0, o_tag 00, o_byte 0, o_busy 0, o_frame_err 0, o_overflow 0.
REQ-032 SHALL, on i_rst asserted mid-transaction, discard all FIFO content and partial byte; after release, stay IDLE until the next start.
REQ-033 SHALL release reset without producing a spurious start/stop when bus lines are idle high.

Verification
REQ-034 Start, address 0xA4 ack 0, stop, i_ready=1 -> sequence tag01; tag00 byte 9'h148; tag11; o_busy 1 then 0; no errors.
REQ-035 Start, 0x90 ack 0, repeat start, 0x91 ack 1, stop -> tags 01,00(9'h120),10,00(9'h123),11.
REQ-036 Start, 4 data bits, stop -> tag01, tag11, one o_frame_err pulse, no byte entry.
REQ-037 i_ready=0, start plus 5 bytes (7 events, FIFO_DEPTH 4) -> first 4 events retained in order, o_overflow=1; draining yields exactly those 4.
REQ-038 FIFO full, push and pop in same cycle -> count unchanged, o_overflow stays 0.
REQ-039 i_rst asserted after 3 bits of a byte -> all outputs reset values; subsequent SCL toggles without start push nothing.
